dsm_sample_sequencer: RTL and testbench

DSM_SAMPLE_SEQUENCER -- requirements
Module: dsm_sample_sequencer

---
 rtl/dsm_sample_sequencer.sv | 138 +++++++++++++
 tb/tb_dsm_sample_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_sample_sequencer.sv
// rtl/dsm_sample_sequencer.sv - 4-entry sample FIFO feeding a held, strobed vin to a delta-sigma modulator
// Optional feature macro: DSM_SEQ_UNDERRUN_HOLD_EN (keep last sample on vin during underrun).
module dsm_sample_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  osr,
    input  logic [19:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [19:0] vin,
    output logic        sample_strobe,
    output logic        underrun,
    output logic [7:0]  underrun_count,
    output logic [2:0]  fifo_level
);

    typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} state_t;

    state_t      state, state_nx;
    logic [19:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [7:0]  cnt, cnt_nx, osr_q, osr_q_nx;
    logic [19:0] vin_nx;
    logic        strobe_nx, pop, wr, fifo_nonempty, count_inc;

    // s_ready comes from the registered level only, so a pop on a full FIFO
    // never opens a write slot in the same cycle.
    assign s_ready       = (fifo_level < 3'd4);
    assign wr            = s_valid & s_ready;
    assign fifo_nonempty = (fifo_level != 3'd0);
    assign underrun      = (state == UNDERRUN);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        osr_q_nx  = osr_q;
        vin_nx    = vin;
        strobe_nx = 1'b0;
        pop       = 1'b0;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                vin_nx = 20'h00000;
                cnt_nx = 8'd0;
                if (enable && fifo_nonempty) begin
                    osr_q_nx  = osr;
                    pop       = 1'b1;
                    vin_nx    = mem[rd_ptr];
                    strobe_nx = 1'b1;
                    cnt_nx    = osr;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nx = IDLE;
                    vin_nx   = 20'h00000;
                    cnt_nx   = 8'd0;
                end else if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (fifo_nonempty) begin
                    pop       = 1'b1;
                    vin_nx    = mem[rd_ptr];
                    strobe_nx = 1'b1;
                    cnt_nx    = osr_q;
                end else begin
                    state_nx  = UNDERRUN;
                    count_inc = 1'b1;
`ifdef DSM_SEQ_UNDERRUN_HOLD_EN
                    vin_nx    = vin;
`else
                    vin_nx    = 20'h00000;
`endif
                end
            end
            UNDERRUN: begin
                if (!enable) begin
                    state_nx = IDLE;
                    vin_nx   = 20'h00000;
                    cnt_nx   = 8'd0;
                end else if (fifo_nonempty) begin
                    pop       = 1'b1;
                    vin_nx    = mem[rd_ptr];
                    strobe_nx = 1'b1;
                    cnt_nx    = osr_q;
                    state_nx  = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
                vin_nx   = 20'h00000;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            osr_q          <= 8'd0;
            vin            <= 20'h00000;
            sample_strobe  <= 1'b0;
            underrun_count <= 8'd0;
            wr_ptr         <= 2'd0;
            rd_ptr         <= 2'd0;
            fifo_level     <= 3'd0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            osr_q         <= osr_q_nx;
            vin           <= vin_nx;
            sample_strobe <= strobe_nx;
            if (count_inc && underrun_count != 8'hFF) begin
                underrun_count <= underrun_count + 8'd1;
            end
            if (wr) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr, pop})
                2'b10:   fifo_level <= fifo_level + 3'd1;
                2'b01:   fifo_level <= fifo_level - 3'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// tb/tb_dsm_sample_sequencer.sv - self-checking bench for dsm_sample_sequencer
module tb_dsm_sample_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  osr = 8'd0;
    logic [19:0] s_data = 20'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [19:0] vin;
    logic        sample_strobe;
    logic        underrun;
    logic [7:0]  underrun_count;
    logic [2:0]  fifo_level;

    int compared = 0;
    int mismatched = 0;

    dsm_sample_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .osr(osr),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .vin(vin),
        .sample_strobe(sample_strobe), .underrun(underrun),
        .underrun_count(underrun_count), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    // Reference model: queue-backed FIFO, a per-sample "cycles still to show" budget
    // and a mode word (0 stopped, 1 playing, 2 starved).
    logic [19:0] m_q[$];
    int          m_mode = 0;
    int          m_left = 0;
    int          m_period = 1;
    logic [19:0] m_vin = 20'h0;
    bit          m_strobe = 1'b0;
    int          m_count = 0;

    task automatic model_present(input int period);
        m_vin    = m_q.pop_front();
        m_strobe = 1'b1;
        m_left   = period - 1;
        m_mode   = 1;
    endtask

    task automatic model_step();
        bit take;
        bit had;
        take = s_valid && (m_q.size() < 4);
        had  = (m_q.size() > 0);
        m_strobe = 1'b0;
        if (!reset) begin
            m_q.delete();
            m_mode = 0; m_left = 0; m_period = 1; m_vin = 20'h0; m_count = 0;
            return;
        end
        if (m_mode != 0 && !enable) begin
            m_mode = 0; m_vin = 20'h0; m_left = 0;
        end else if (m_mode == 0) begin
            m_vin = 20'h0;
            if (enable && had) begin
                m_period = int'(osr) + 1;
                model_present(m_period);
            end
        end else if (m_mode == 1 && m_left > 0) begin
            m_left--;
        end else if (had) begin
            model_present(m_period);
        end else if (m_mode == 1) begin
            m_mode = 2;
            if (m_count < 255) m_count++;
`ifndef DSM_SEQ_UNDERRUN_HOLD_EN
            m_vin = 20'h0;
`endif
        end
        if (take) m_q.push_back(s_data);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; s_valid = 1'b0; enable = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b1; s_data = 20'h55555; enable = 1'b1;
        tick();
        compared++;
        if (vin !== 20'h0 || fifo_level !== 3'd0 || sample_strobe !== 1'b0 ||
            underrun !== 1'b0 || underrun_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_state: vin=%h lvl=%0d stb=%b und=%b cnt=%0d, required all zero",
                     vin, fifo_level, sample_strobe, underrun, underrun_count);
        end
        reset = 1'b1; s_valid = 1'b0; enable = 1'b0;
        compared++;
        if (s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready: got %b required 1", s_ready);
        end
        tick();
    endtask

    task automatic test_two_samples();
        do_reset();
        enable = 1'b1; osr = 8'd3;
        s_valid = 1'b1; s_data = 20'h12345;
        tick();
        s_data = 20'h0ABCD;
        tick();
        s_valid = 1'b0;
        osr = 8'd0;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (vin !== 20'h12345 || sample_strobe !== (i == 0)) begin
                mismatched++;
                $display("FAIL hold_first[%0d]: vin=%h stb=%b required 12345 %b",
                         i, vin, sample_strobe, (i == 0));
            end
            tick();
        end
        compared++;
        if (vin !== 20'h0ABCD || sample_strobe !== 1'b1) begin
            mismatched++;
            $display("FAIL second_sample: vin=%h stb=%b required 0abcd 1", vin, sample_strobe);
        end
    endtask

    task automatic test_stream();
        logic [19:0] prev;
        do_reset();
        enable = 1'b1; osr = 8'd0; s_valid = 1'b1;
        prev = 20'($urandom);
        s_data = prev;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) s_valid = 1'b0;
            s_data = 20'($urandom);
            tick();
            compared++;
            if (vin !== prev || sample_strobe !== 1'b1 || fifo_level > 3'd1) begin
                mismatched++;
                $display("FAIL stream[%0d]: vin=%h stb=%b lvl=%0d required %h 1 <=1",
                         k, vin, sample_strobe, fifo_level, prev);
            end
            prev = s_data;
        end
    endtask

    task automatic test_full();
        do_reset();
        enable = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 20'h1000 + 20'(i);
            compared++;
            if (s_ready !== (i < 4)) begin
                mismatched++;
                $display("FAIL full_ready[%0d]: got %b required %b", i, s_ready, (i < 4));
            end
            tick();
        end
        s_valid = 1'b0;
        compared++;
        if (fifo_level !== 3'd4 || s_ready !== 1'b0 || vin !== 20'h0) begin
            mismatched++;
            $display("FAIL full_state: lvl=%0d rdy=%b vin=%h required 4 0 0", fifo_level, s_ready, vin);
        end
        enable = 1'b1;
        tick();
        compared++;
        if (vin !== 20'h01000 || fifo_level !== 3'd3) begin
            mismatched++;
            $display("FAIL full_drain: vin=%h lvl=%0d required 01000 3", vin, fifo_level);
        end
    endtask

    task automatic test_underrun();
        logic [19:0] exp_vin;
        do_reset();
        enable = 1'b1; osr = 8'd2; s_valid = 1'b1; s_data = 20'hA5A5A;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        tick();
        compared++;
        if (underrun !== 1'b0 || vin !== 20'hA5A5A) begin
            mismatched++;
            $display("FAIL underrun_early: und=%b vin=%h required 0 a5a5a", underrun, vin);
        end
        tick();
`ifdef DSM_SEQ_UNDERRUN_HOLD_EN
        exp_vin = 20'hA5A5A;
`else
        exp_vin = 20'h0;
`endif
        compared++;
        if (underrun !== 1'b1 || underrun_count !== 8'd1 || vin !== exp_vin) begin
            mismatched++;
            $display("FAIL underrun_entry: und=%b cnt=%0d vin=%h required 1 1 %h",
                     underrun, underrun_count, vin, exp_vin);
        end
        s_valid = 1'b1; s_data = 20'h5A5A5;
        tick();
        s_valid = 1'b0;
        tick();
        compared++;
        if (underrun !== 1'b0 || vin !== 20'h5A5A5 || sample_strobe !== 1'b1) begin
            mismatched++;
            $display("FAIL underrun_resume: und=%b vin=%h stb=%b required 0 5a5a5 1",
                     underrun, vin, sample_strobe);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1'b1; osr = 8'd0;
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'b1; s_data = 20'(i);
            tick();
            s_valid = 1'b0;
            tick();
            tick();
        end
        compared++;
        if (underrun_count !== 8'd255 || underrun !== 1'b1) begin
            mismatched++;
            $display("FAIL saturate: cnt=%0d und=%b required 255 1", underrun_count, underrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1; osr = 8'd7; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 20'h300 + 20'(i);
            tick();
        end
        s_valid = 1'b0;
        compared++;
        if (fifo_level !== 3'd3 || vin !== 20'h00300) begin
            mismatched++;
            $display("FAIL mid_setup: lvl=%0d vin=%h required 3 00300", fifo_level, vin);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        compared++;
        if (fifo_level !== 3'd0 || vin !== 20'h0 || sample_strobe !== 1'b0 || s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset: lvl=%0d vin=%h stb=%b rdy=%b required 0 0 0 1",
                     fifo_level, vin, sample_strobe, s_ready);
        end
        tick();
        compared++;
        if (vin !== 20'h0 || underrun !== 1'b0 || fifo_level !== 3'd0) begin
            mismatched++;
            $display("FAIL mid_idle: vin=%h und=%b lvl=%0d required 0 0 0", vin, underrun, fifo_level);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset   = ($urandom_range(0, 99) != 0);
            enable  = ($urandom_range(0, 15) != 0);
            osr     = 8'($urandom_range(0, 3));
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 20'($urandom);
            tick();
            compared++;
            if (vin !== m_vin || sample_strobe !== m_strobe) begin
                mismatched++;
                $display("FAIL rand_vin cyc %0d: vin=%h stb=%b required %h %b",
                         c, vin, sample_strobe, m_vin, m_strobe);
            end
            compared++;
            if (fifo_level !== 3'(m_q.size()) || s_ready !== (m_q.size() < 4)) begin
                mismatched++;
                $display("FAIL rand_fifo cyc %0d: lvl=%0d rdy=%b required %0d %b",
                         c, fifo_level, s_ready, m_q.size(), (m_q.size() < 4));
            end
            compared++;
            if (underrun !== (m_mode == 2) || underrun_count !== 8'(m_count)) begin
                mismatched++;
                $display("FAIL rand_underrun cyc %0d: und=%b cnt=%0d required %b %0d",
                         c, underrun, underrun_count, (m_mode == 2), m_count);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_two_samples();
        test_stream();
        test_full();
        test_underrun();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
